// File: rtl/alu_muldiv_if.sv
// ============================================================================
//  Module      : alu_muldiv_if
//  Description : Command / result bundle between the multi-cycle control path
//                and alu_muldiv_unit. The overflow signal exists only when
//                ALU_OVERFLOW_TRAP_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       alu_op;
  logic [5:0]       funct;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;
  logic             done;
  logic             op_error;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef ALU_OVERFLOW_TRAP_EN
  logic             overflow;
`endif

  // Control side: issues commands, observes results
  modport master (
    output start, alu_op, funct, operand_a, operand_b,
    input  result, zero, busy, done, op_error, hi, lo
`ifdef ALU_OVERFLOW_TRAP_EN
    , input overflow
`endif
  );

  // Execution unit side
  modport slave (
    input  start, alu_op, funct, operand_a, operand_b,
    output result, zero, busy, done, op_error, hi, lo
`ifdef ALU_OVERFLOW_TRAP_EN
    , output overflow
`endif
  );
endinterface

`default_nettype wire

// File: rtl/alu_muldiv_unit.sv
// ============================================================================
//  Module      : alu_muldiv_unit
//  Description : Registered ALU with ALU-op / funct decoding, plus iterative
//                shift-add multiply and restoring divide into HI/LO.
//                Optional macro ALU_OVERFLOW_TRAP_EN adds a signed-overflow
//                flag for add/sub.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  wire logic   clock,
  input  wire logic   reset,
  alu_muldiv_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [5:0] c_f_add   = 6'b100000;
  localparam logic [5:0] c_f_sub   = 6'b100010;
  localparam logic [5:0] c_f_and   = 6'b100100;
  localparam logic [5:0] c_f_or    = 6'b100101;
  localparam logic [5:0] c_f_xor   = 6'b100110;
  localparam logic [5:0] c_f_nor   = 6'b100111;
  localparam logic [5:0] c_f_slt   = 6'b101010;
  localparam logic [5:0] c_f_sltu  = 6'b101011;
  localparam logic [5:0] c_f_mfhi  = 6'b010000;
  localparam logic [5:0] c_f_mflo  = 6'b010010;
  localparam logic [5:0] c_f_mult  = 6'b011000;
  localparam logic [5:0] c_f_multu = 6'b011001;
  localparam logic [5:0] c_f_div   = 6'b011010;
  localparam logic [5:0] c_f_divu  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;     // partial product high half / remainder
  logic [WIDTH-1:0] sh_q, sh_d;       // multiplier -> product low / dividend -> quotient
  logic [WIDTH-1:0] m_q, m_d;         // multiplicand / divisor magnitude
  logic             is_div_q, is_div_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             op_error_q, op_error_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
`ifdef ALU_OVERFLOW_TRAP_EN
  logic             overflow_q, overflow_d;
`endif

  // Single-cycle datapath and decode
  logic [WIDTH-1:0] w_a, w_b;
  logic [WIDTH-1:0] w_sum, w_diff;
  logic [WIDTH-1:0] w_sc_result;
  logic             w_sc_error;
  logic             w_is_mc;
  logic             w_mc_div;
  logic             w_mc_signed;
`ifdef ALU_OVERFLOW_TRAP_EN
  logic             w_add_ovf, w_sub_ovf, w_sc_ovf;
`endif

  assign w_a    = bus.operand_a;
  assign w_b    = bus.operand_b;
  assign w_sum  = w_a + w_b;
  assign w_diff = w_a - w_b;

`ifdef ALU_OVERFLOW_TRAP_EN
  // Signed overflow: result sign disagrees with operand_a when it must not
  assign w_add_ovf = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1]  != w_a[WIDTH-1]);
  assign w_sub_ovf = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);
`endif

  // Decode alu_op/funct into a single-cycle result or a multi-cycle launch
  always_comb begin
    w_sc_result = '0;
    w_sc_error  = 1'b0;
    w_is_mc     = 1'b0;
    w_mc_div    = 1'b0;
    w_mc_signed = 1'b0;
`ifdef ALU_OVERFLOW_TRAP_EN
    w_sc_ovf    = 1'b0;
`endif
    case (bus.alu_op)
      2'b00: begin
        w_sc_result = w_sum;
`ifdef ALU_OVERFLOW_TRAP_EN
        w_sc_ovf    = w_add_ovf;
`endif
      end
      2'b01: begin
        w_sc_result = w_diff;
`ifdef ALU_OVERFLOW_TRAP_EN
        w_sc_ovf    = w_sub_ovf;
`endif
      end
      2'b10: begin
        case (bus.funct)
          c_f_add: begin
            w_sc_result = w_sum;
`ifdef ALU_OVERFLOW_TRAP_EN
            w_sc_ovf    = w_add_ovf;
`endif
          end
          c_f_sub: begin
            w_sc_result = w_diff;
`ifdef ALU_OVERFLOW_TRAP_EN
            w_sc_ovf    = w_sub_ovf;
`endif
          end
          c_f_and:   w_sc_result = w_a & w_b;
          c_f_or:    w_sc_result = w_a | w_b;
          c_f_xor:   w_sc_result = w_a ^ w_b;
          c_f_nor:   w_sc_result = ~(w_a | w_b);
          c_f_slt:   w_sc_result = {{(WIDTH-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
          c_f_sltu:  w_sc_result = {{(WIDTH-1){1'b0}}, (w_a < w_b)};
          c_f_mfhi:  w_sc_result = hi_q;
          c_f_mflo:  w_sc_result = lo_q;
          c_f_mult:  begin w_is_mc = 1'b1; w_mc_signed = 1'b1; end
          c_f_multu: begin w_is_mc = 1'b1; end
          c_f_div:   begin w_is_mc = 1'b1; w_mc_div = 1'b1; w_mc_signed = 1'b1; end
          c_f_divu:  begin w_is_mc = 1'b1; w_mc_div = 1'b1; end
          default:   w_sc_error = 1'b1;
        endcase
      end
      default: w_sc_error = 1'b1;
    endcase
  end

  // Operand magnitudes; signed ops work on absolute values
  logic             w_neg_a, w_neg_b;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;

  assign w_neg_a = w_mc_signed && w_a[WIDTH-1];
  assign w_neg_b = w_mc_signed && w_b[WIDTH-1];
  assign w_mag_a = w_neg_a ? (~w_a + 1'b1) : w_a;
  assign w_mag_b = w_neg_b ? (~w_b + 1'b1) : w_b;

  // One iteration step of the shift-add multiplier / restoring divider
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH-1:0] w_div_diff;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_step_acc, w_step_sh;

  assign w_mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
  assign w_div_shift = {acc_q, sh_q[WIDTH-1]};
  // Remainder < divisor, so the difference always fits in WIDTH bits when taken
  assign w_div_diff  = w_div_shift[WIDTH-1:0] - m_q;
  assign w_div_ge    = (w_div_shift >= {1'b0, m_q});

  always_comb begin
    if (is_div_q) begin
      w_step_acc = w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
      w_step_sh  = {sh_q[WIDTH-2:0], w_div_ge};
    end else begin
      w_step_acc = w_mul_sum[WIDTH:1];
      w_step_sh  = {w_mul_sum[0], sh_q[WIDTH-1:1]};
    end
  end

  // Sign correction of the final step, producing the HI/LO write values
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_fin_hi, w_fin_lo;

  assign w_prod     = {w_step_acc, w_step_sh};
  assign w_prod_fix = (sign_a_q ^ sign_b_q) ? (~w_prod + 1'b1) : w_prod;

  always_comb begin
    if (is_div_q) begin
      // Truncating division: remainder follows the dividend's sign
      w_fin_hi = sign_a_q ? (~w_step_acc + 1'b1) : w_step_acc;
      if (div_zero_q)
        w_fin_lo = '1;
      else
        w_fin_lo = (sign_a_q ^ sign_b_q) ? (~w_step_sh + 1'b1) : w_step_sh;
    end else begin
      w_fin_hi = w_prod_fix[2*WIDTH-1:WIDTH];
      w_fin_lo = w_prod_fix[WIDTH-1:0];
    end
  end

  // Control FSM next-state and registered-output computation
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    sh_d       = sh_q;
    m_d        = m_q;
    is_div_d   = is_div_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    div_zero_d = div_zero_q;
    result_d   = result_q;
    zero_d     = zero_q;
    busy_d     = busy_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    op_error_d = 1'b0;
`ifdef ALU_OVERFLOW_TRAP_EN
    overflow_d = 1'b0;
`endif
    case (state_q)
      IDLE, FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (bus.start) begin
          if (w_is_mc) begin
            state_d    = RUN;
            busy_d     = 1'b1;
            cnt_d      = CNT_W'(WIDTH);
            acc_d      = '0;
            is_div_d   = w_mc_div;
            sign_a_d   = w_neg_a;
            sign_b_d   = w_neg_b;
            div_zero_d = w_mc_div && (w_b == '0);
            m_d        = w_mc_div ? w_mag_b : w_mag_a;
            sh_d       = w_mc_div ? w_mag_a : w_mag_b;
          end else begin
            result_d   = w_sc_result;
            zero_d     = (w_sc_result == '0);
            done_d     = 1'b1;
            op_error_d = w_sc_error;
`ifdef ALU_OVERFLOW_TRAP_EN
            overflow_d = w_sc_ovf;
`endif
          end
        end
      end
      RUN: begin
        acc_d = w_step_acc;
        sh_d  = w_step_sh;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d    = FINISH;
          busy_d     = 1'b0;
          hi_d       = w_fin_hi;
          lo_d       = w_fin_lo;
          result_d   = w_fin_lo;
          zero_d     = (w_fin_lo == '0);
          done_d     = 1'b1;
          op_error_d = div_zero_q;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      sh_q       <= '0;
      m_q        <= '0;
      is_div_q   <= 1'b0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      div_zero_q <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      op_error_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
`ifdef ALU_OVERFLOW_TRAP_EN
      overflow_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      sh_q       <= sh_d;
      m_q        <= m_d;
      is_div_q   <= is_div_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      div_zero_q <= div_zero_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      op_error_q <= op_error_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
`ifdef ALU_OVERFLOW_TRAP_EN
      overflow_q <= overflow_d;
`endif
    end
  end

  assign bus.result   = result_q;
  assign bus.zero     = zero_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.op_error = op_error_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
`ifdef ALU_OVERFLOW_TRAP_EN
  assign bus.overflow = overflow_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_muldiv_unit.sv
// ============================================================================
//  Module      : tb_alu_muldiv_unit
//  Description : Directed self-checking bench for alu_muldiv_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_muldiv_unit;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  alu_muldiv_if #(.WIDTH(32)) bus ();

  alu_muldiv_unit #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a command for one edge, then scramble the operands
  task automatic launch(input logic [1:0] op, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b);
    bus.alu_op    = op;
    bus.funct     = fn;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.operand_a = 32'hDEAD_BEEF;
    bus.operand_b = 32'h0BAD_F00D;
  endtask

  // Wait (bounded) for done; cyc counts cycles with the start edge's successor as 1
  task automatic wait_done(input int first, output int cyc, output int busy_cnt);
    cyc = first;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && cyc < 100) begin
      if (bus.busy === 1'b1) busy_cnt++;
      tick();
      cyc++;
    end
  endtask

  int cyc;
  int bcnt;
  int dcnt;

  initial begin
    bus.start     = 1'b0;
    bus.alu_op    = 2'b00;
    bus.funct     = 6'b0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_result", bus.result, 32'h0);
    check("rst_zero", {31'b0, bus.zero}, 32'h1);
    check("rst_busy", {31'b0, bus.busy}, 32'h0);
    check("rst_done", {31'b0, bus.done}, 32'h0);
    check("rst_operr", {31'b0, bus.op_error}, 32'h0);
    check("rst_hi", bus.hi, 32'h0);
    check("rst_lo", bus.lo, 32'h0);
`ifdef ALU_OVERFLOW_TRAP_EN
    check("rst_ovf", {31'b0, bus.overflow}, 32'h0);
`endif

    // AND
    launch(2'b10, 6'b100100, 32'hF0F0_00FF, 32'h0FF0_0F0F);
    check("and_result", bus.result, 32'h00F0_000F);
    check("and_done", {31'b0, bus.done}, 32'h1);
    check("and_busy", {31'b0, bus.busy}, 32'h0);
    check("and_zero", {31'b0, bus.zero}, 32'h0);
    tick();
    check("and_done_pulse", {31'b0, bus.done}, 32'h0);

    // add wrap, sub, funct ops
    launch(2'b00, 6'b0, 32'hFFFF_FFFF, 32'h1);
    check("add_wrap", bus.result, 32'h0);
    check("add_wrap_zero", {31'b0, bus.zero}, 32'h1);
    launch(2'b01, 6'b0, 32'd5, 32'd3);
    check("sub", bus.result, 32'd2);
    launch(2'b10, 6'b100010, 32'd3, 32'd5);
    check("f_sub", bus.result, 32'hFFFF_FFFE);
    launch(2'b10, 6'b100101, 32'hF0F0_0000, 32'h0000_0F0F);
    check("or", bus.result, 32'hF0F0_0F0F);
    launch(2'b10, 6'b100110, 32'hFF00_FF00, 32'h0F0F_0F0F);
    check("xor", bus.result, 32'hF00F_F00F);
    launch(2'b10, 6'b100111, 32'h0, 32'h0);
    check("nor", bus.result, 32'hFFFF_FFFF);
    launch(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'h1);
    check("slt", bus.result, 32'h1);
    launch(2'b10, 6'b101011, 32'hFFFF_FFFF, 32'h1);
    check("sltu", bus.result, 32'h0);
    check("sltu_zero", {31'b0, bus.zero}, 32'h1);

    // signed mult -2 * 3
    launch(2'b10, 6'b011000, 32'hFFFF_FFFE, 32'd3);
    wait_done(1, cyc, bcnt);
    check("mult_latency", cyc, 33);
    check("mult_busy_cycles", bcnt, 32);
    check("mult_busy_at_done", {31'b0, bus.busy}, 32'h0);
    check("mult_hi", bus.hi, 32'hFFFF_FFFF);
    check("mult_lo", bus.lo, 32'hFFFF_FFFA);
    check("mult_result", bus.result, 32'hFFFF_FFFA);
    check("mult_operr", {31'b0, bus.op_error}, 32'h0);
    tick();
    check("mult_done_pulse", {31'b0, bus.done}, 32'h0);
    launch(2'b10, 6'b010000, 32'h0, 32'h0);
    check("mfhi", bus.result, 32'hFFFF_FFFF);
    launch(2'b10, 6'b010010, 32'h0, 32'h0);
    check("mflo", bus.result, 32'hFFFF_FFFA);

    // reserved op and unknown funct
    launch(2'b11, 6'b100000, 32'd7, 32'd9);
    check("resv_result", bus.result, 32'h0);
    check("resv_operr", {31'b0, bus.op_error}, 32'h1);
    check("resv_done", {31'b0, bus.done}, 32'h1);
    check("resv_hi_kept", bus.hi, 32'hFFFF_FFFF);
    launch(2'b10, 6'b000000, 32'd7, 32'd9);
    check("badfn_operr", {31'b0, bus.op_error}, 32'h1);
    check("badfn_lo_kept", bus.lo, 32'hFFFF_FFFA);

    // unsigned mult boundary
    launch(2'b10, 6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1, cyc, bcnt);
    check("multu_latency", cyc, 33);
    check("multu_hi", bus.hi, 32'hFFFF_FFFE);
    check("multu_lo", bus.lo, 32'h0000_0001);

    // signed div -7 / 2
    launch(2'b10, 6'b011010, 32'hFFFF_FFF9, 32'd2);
    wait_done(1, cyc, bcnt);
    check("div_latency", cyc, 33);
    check("div_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_hi", bus.hi, 32'hFFFF_FFFF);

    // divu 100 / 7
    launch(2'b10, 6'b011011, 32'd100, 32'd7);
    wait_done(1, cyc, bcnt);
    check("divu_lo", bus.lo, 32'd14);
    check("divu_hi", bus.hi, 32'd2);
    check("divu_result", bus.result, 32'd14);

    // divide by zero
    launch(2'b10, 6'b011010, 32'h0000_1234, 32'h0);
    wait_done(1, cyc, bcnt);
    check("dz_latency", cyc, 33);
    check("dz_lo", bus.lo, 32'hFFFF_FFFF);
    check("dz_hi", bus.hi, 32'h0000_1234);
    check("dz_operr", {31'b0, bus.op_error}, 32'h1);

    // most-negative / -1
    launch(2'b10, 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1, cyc, bcnt);
    check("mneg_lo", bus.lo, 32'h8000_0000);
    check("mneg_hi", bus.hi, 32'h0);
    check("mneg_operr", {31'b0, bus.op_error}, 32'h0);

    // start while busy is ignored
    launch(2'b10, 6'b011000, 32'hFFFF_FFFE, 32'd3);
    repeat (3) tick();
    bus.alu_op    = 2'b10;
    bus.funct     = 6'b011011;
    bus.operand_a = 32'd100;
    bus.operand_b = 32'd7;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
    wait_done(5, cyc, bcnt);
    check("ign_latency", cyc, 33);
    check("ign_hi", bus.hi, 32'hFFFF_FFFF);
    check("ign_lo", bus.lo, 32'hFFFF_FFFA);

    // reset mid-operation aborts
    tick();
    launch(2'b10, 6'b011000, 32'hFFFF_FFFE, 32'd3);
    repeat (3) tick();
    bus.funct     = 6'b011011;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
    repeat (4) tick();
    check("pre_rst_busy", {31'b0, bus.busy}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", {31'b0, bus.busy}, 32'h0);
    check("abort_hi", bus.hi, 32'h0);
    check("abort_lo", bus.lo, 32'h0);
    check("abort_result", bus.result, 32'h0);
    check("abort_zero", {31'b0, bus.zero}, 32'h1);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) dcnt++;
      tick();
    end
    check("abort_no_done", dcnt, 0);

`ifdef ALU_OVERFLOW_TRAP_EN
    launch(2'b00, 6'b0, 32'h7FFF_FFFF, 32'h1);
    check("ovf_add_result", bus.result, 32'h8000_0000);
    check("ovf_add_flag", {31'b0, bus.overflow}, 32'h1);
    launch(2'b01, 6'b0, 32'd5, 32'd3);
    check("ovf_sub_result", bus.result, 32'd2);
    check("ovf_sub_flag", {31'b0, bus.overflow}, 32'h0);
    launch(2'b10, 6'b100010, 32'h8000_0000, 32'h1);
    check("ovf_fsub_flag", {31'b0, bus.overflow}, 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
